aes128_inv_key_sched: RTL and testbench



---
 rtl/aes_pkg.sv | 66 ++++++
 rtl/aes128_inv_key_sched_step.sv | 39 +++
 rtl/aes128_inv_key_sched.sv | 91 +++++++++
 tb/tb_aes128_inv_key_sched.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers for the key-schedule slice: S-box, RotWord, rcon and FSM encoding.
package aes_pkg;
  localparam int NR = 10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_EMIT   = 2'd2;
  localparam logic [1:0] ST_FIN    = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    EXPAND = ST_EXPAND,
    EMIT   = ST_EMIT,
    FIN    = ST_FIN
  } state_t;

  function automatic logic [31:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0: rcon = 32'h0100_0000;
      4'd1: rcon = 32'h0200_0000;
      4'd2: rcon = 32'h0400_0000;
      4'd3: rcon = 32'h0800_0000;
      4'd4: rcon = 32'h1000_0000;
      4'd5: rcon = 32'h2000_0000;
      4'd6: rcon = 32'h4000_0000;
      4'd7: rcon = 32'h8000_0000;
      4'd8: rcon = 32'h1b00_0000;
      4'd9: rcon = 32'h3600_0000;
      default: rcon = 32'h0;
    endcase
  endfunction

  // Forward S-box: high nibble picks a 16-byte row, low nibble picks the byte (byte 0 at MSB).
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    logic [127:0] row;
    row = '0;
    case (b[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
      default: row = '0;
    endcase
    sub_byte = row[{~b[3:0], 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction
endpackage

// File: rtl/aes128_inv_key_sched_step.sv
// One AES-128 key-schedule round, forward (dir=0) or inverse (dir=1), purely combinational.
module aes128_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [3:0]   rc,
  input  logic         dir,
  output logic [127:0] key_nxt
);
  logic [31:0] k0, k1, k2, k3;
  logic [31:0] n0, n1, n2, n3;
  logic [31:0] t;

  assign {k0, k1, k2, k3} = key;

  always_comb begin
    n0 = '0;
    n1 = '0;
    n2 = '0;
    n3 = '0;
    t  = '0;
    if (!dir) begin
      t  = sub_word(rot_word(k3)) ^ rcon(rc);
      n0 = k0 ^ t;
      n1 = k1 ^ n0;
      n2 = k2 ^ n1;
      n3 = k3 ^ n2;
    end else begin
      // Recover the previous w3 first; the SubWord term depends on it.
      n3 = k3 ^ k2;
      n2 = k2 ^ k1;
      n1 = k1 ^ k0;
      t  = sub_word(rot_word(n3)) ^ rcon(rc);
      n0 = k0 ^ t;
    end
  end

  assign key_nxt = {n0, n1, n2, n3};
endmodule

// File: rtl/aes128_inv_key_sched.sv
// Expands the cipher key forward to round 10, then streams round keys 10..0 over valid/ready.
module aes128_inv_key_sched
  import aes_pkg::*;
#(
  parameter bit BYPASS_FWD = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx
  ,
  output logic         done
);
  state_t       state, state_nxt;
  logic [127:0] key_r, key_d, step_out;
  logic [3:0]   rc, rc_d, idx, idx_d, step_rc;
  logic         dir;

  // Single step instance shared by both phases; EMIT walks backwards from the current index.
  assign dir     = (state == EMIT);
  assign step_rc = dir ? (idx - 4'd1) : rc;

  aes128_key_step u_step (
    .key     (key_r),
    .rc      (step_rc),
    .dir     (dir),
    .key_nxt (step_out)
  );

  always_comb begin
    state_nxt = state;
    key_d     = key_r;
    rc_d      = rc;
    idx_d     = idx;
    case (state)
      IDLE: if (start) begin
        key_d = key_in;
        if (BYPASS_FWD) begin
          state_nxt = EMIT;
          idx_d     = 4'(NR);
        end else begin
          state_nxt = EXPAND;
          rc_d      = 4'd0;
        end
      end
      EXPAND: begin
        key_d = step_out;
        rc_d  = rc + 4'd1;
        if (rc == 4'(NR - 1)) begin
          state_nxt = EMIT;
          idx_d     = 4'(NR);
        end
      end
      EMIT: if (out_ready) begin
        if (idx != 4'd0) begin
          key_d = step_out;
          idx_d = idx - 4'd1;
        end else begin
          state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      key_r <= '0;
      rc    <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      key_r <= key_d;
      rc    <= rc_d;
      idx   <= idx_d;
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == EMIT);
  assign done      = (state == FIN);
  assign round_key = key_r;
  assign round_idx = idx;
endmodule

// File: tb/tb_aes128_inv_key_sched.sv
// Directed bench: FIPS-197 key sequence, backpressure, bypass, ignored start, mid-run reset, zero key.
module tb_aes128_inv_key_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start0, start1, rdy0, rdy1;
  logic [127:0] key0, key1;
  logic         busy0, busy1, ov0, ov1, done0, done1;
  logic [127:0] rk0, rk1;
  logic [3:0]   ri0, ri1;

  aes128_inv_key_sched #(.BYPASS_FWD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .key_in(key0), .busy(busy0), .out_valid(ov0),
    .out_ready(rdy0), .round_key(rk0), .round_idx(ri0), .done(done0));

  aes128_inv_key_sched #(.BYPASS_FWD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .key_in(key1), .busy(busy1), .out_valid(ov1),
    .out_ready(rdy1), .round_key(rk1), .round_idx(ri1), .done(done1));

  int vectors = 0;
  int miscompares = 0;

  logic [127:0] exp_rk [0:10];
  logic [127:0] obs_key [$];
  int           obs_idx [$];
  int           lat, dones, done_at, last_hs, stall_bad, stall_seen;
  logic         busy_at_done, busy_post;
  logic [127:0] final_rk;

  // Drives one run on the selected DUT and records what it emits; tests judge the record.
  task automatic collect(input int sel, input logic [127:0] k, input int stall_idx,
                         input int stall_n, input bit inj);
    logic v, d, b;
    logic [127:0] rk, hold_k;
    logic [3:0] ri, hold_i;
    int stalled;
    obs_key.delete();
    obs_idx.delete();
    lat = -1; dones = 0; done_at = -1; last_hs = -1; stall_bad = 0; stall_seen = 0;
    stalled = 0; busy_at_done = 1'b0; busy_post = 1'b1; hold_k = '0; hold_i = '0;
    @(negedge clk);
    if (sel == 0) begin start0 = 1'b1; key0 = k; rdy0 = 1'b1; end
    else begin start1 = 1'b1; key1 = k; rdy1 = 1'b1; end
    for (int cnt = 1; cnt <= 200; cnt++) begin
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      v  = (sel == 0) ? ov0 : ov1;
      d  = (sel == 0) ? done0 : done1;
      b  = (sel == 0) ? busy0 : busy1;
      rk = (sel == 0) ? rk0 : rk1;
      ri = (sel == 0) ? ri0 : ri1;
      final_rk = rk;
      if (done_at >= 0 && cnt == done_at + 1) busy_post = b;
      if (d) begin
        dones++;
        if (done_at < 0) begin done_at = cnt; busy_at_done = b; end
      end
      if (v) begin
        if (lat < 0) lat = cnt;
        if (stall_idx >= 0 && ri == stall_idx && stalled < stall_n) begin
          if (stalled == 0) begin hold_k = rk; hold_i = ri; end
          else if (rk !== hold_k || ri !== hold_i) stall_bad++;
          stalled++;
          stall_seen++;
          if (sel == 0) rdy0 = 1'b0; else rdy1 = 1'b0;
        end else begin
          if (sel == 0) rdy0 = 1'b1; else rdy1 = 1'b1;
          obs_key.push_back(rk);
          obs_idx.push_back(int'(ri));
          last_hs = cnt;
        end
      end
      if (inj && (cnt == 4 || (v && ri == 4'd6))) begin
        if (sel == 0) begin start0 = 1'b1; key0 = ~k; end
        else begin start1 = 1'b1; key1 = ~k; end
      end
      if (done_at >= 0 && cnt >= done_at + 3) break;
    end
    start0 = 1'b0; start1 = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy0, ov0, done0, ri0, rk0} !== '0) begin
      miscompares++;
      $display("FAIL reset_dut0: got busy=%b valid=%b done=%b idx=%0d key=%h, want all zero",
               busy0, ov0, done0, ri0, rk0);
    end
    vectors++;
    if ({busy1, ov1, done1, ri1, rk1} !== '0) begin
      miscompares++;
      $display("FAIL reset_dut1: got busy=%b valid=%b done=%b idx=%0d key=%h, want all zero",
               busy1, ov1, done1, ri1, rk1);
    end
    rst = 1'b0;
  endtask

  task automatic test_fips();
    collect(0, exp_rk[0], -1, 0, 1'b0);
    vectors++;
    if (lat !== 11) begin miscompares++; $display("FAIL fips_latency: got %0d want 11", lat); end
    vectors++;
    if (obs_key.size() !== 11) begin
      miscompares++; $display("FAIL fips_count: got %0d keys want 11", obs_key.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        vectors++;
        if (obs_key[i] !== exp_rk[10-i] || obs_idx[i] !== 10 - i) begin
          miscompares++;
          $display("FAIL fips_key[%0d]: got idx %0d key %h want idx %0d key %h",
                   i, obs_idx[i], obs_key[i], 10 - i, exp_rk[10-i]);
        end
      end
    end
    vectors++;
    if (dones !== 1 || done_at !== last_hs + 1) begin
      miscompares++;
      $display("FAIL fips_done: got %0d pulses at %0d want 1 at %0d", dones, done_at, last_hs + 1);
    end
    vectors++;
    if (busy_at_done !== 1'b1 || busy_post !== 1'b0) begin
      miscompares++;
      $display("FAIL fips_busy: got at_done=%b after=%b want 1 then 0", busy_at_done, busy_post);
    end
    vectors++;
    if (final_rk !== exp_rk[0]) begin
      miscompares++; $display("FAIL fips_hold: got %h want %h", final_rk, exp_rk[0]);
    end
  endtask

  task automatic test_backpressure();
    collect(0, exp_rk[0], 7, 5, 1'b0);
    vectors++;
    if (stall_seen !== 5 || stall_bad !== 0) begin
      miscompares++;
      $display("FAIL bp_stable: got %0d stalls %0d changes want 5 stalls 0 changes", stall_seen, stall_bad);
    end
    vectors++;
    if (obs_key.size() !== 11) begin
      miscompares++; $display("FAIL bp_count: got %0d handshakes want 11", obs_key.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        vectors++;
        if (obs_key[i] !== exp_rk[10-i] || obs_idx[i] !== 10 - i) begin
          miscompares++;
          $display("FAIL bp_key[%0d]: got idx %0d key %h want idx %0d key %h",
                   i, obs_idx[i], obs_key[i], 10 - i, exp_rk[10-i]);
        end
      end
    end
    vectors++;
    if (dones !== 1) begin miscompares++; $display("FAIL bp_done: got %0d pulses want 1", dones); end
  endtask

  task automatic test_bypass();
    collect(1, exp_rk[10], -1, 0, 1'b0);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL byp_latency: got %0d want 1", lat); end
    vectors++;
    if (obs_key.size() !== 11) begin
      miscompares++; $display("FAIL byp_count: got %0d keys want 11", obs_key.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        vectors++;
        if (obs_key[i] !== exp_rk[10-i] || obs_idx[i] !== 10 - i) begin
          miscompares++;
          $display("FAIL byp_key[%0d]: got idx %0d key %h want idx %0d key %h",
                   i, obs_idx[i], obs_key[i], 10 - i, exp_rk[10-i]);
        end
      end
    end
    vectors++;
    if (dones !== 1 || final_rk !== exp_rk[0]) begin
      miscompares++;
      $display("FAIL byp_end: got %0d pulses final %h want 1 pulse final %h", dones, final_rk, exp_rk[0]);
    end
  endtask

  task automatic test_start_ignored();
    collect(0, exp_rk[0], -1, 0, 1'b1);
    vectors++;
    if (lat !== 11) begin miscompares++; $display("FAIL ign_latency: got %0d want 11", lat); end
    vectors++;
    if (obs_key.size() !== 11) begin
      miscompares++; $display("FAIL ign_count: got %0d keys want 11", obs_key.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        vectors++;
        if (obs_key[i] !== exp_rk[10-i] || obs_idx[i] !== 10 - i) begin
          miscompares++;
          $display("FAIL ign_key[%0d]: got idx %0d key %h want idx %0d key %h",
                   i, obs_idx[i], obs_key[i], 10 - i, exp_rk[10-i]);
        end
      end
    end
    vectors++;
    if (dones !== 1) begin miscompares++; $display("FAIL ign_done: got %0d pulses want 1", dones); end
  endtask

  task automatic test_rst_mid();
    bit hit;
    int quiet_bad;
    hit = 1'b0;
    quiet_bad = 0;
    @(negedge clk);
    start0 = 1'b1; key0 = exp_rk[0]; rdy0 = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (ov0 && ri0 == 4'd5) begin hit = 1'b1; break; end
    end
    vectors++;
    if (!hit) begin miscompares++; $display("FAIL rst_reach_idx5: got timeout want idx 5 valid"); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({busy0, ov0, done0, ri0, rk0} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got busy=%b valid=%b done=%b idx=%0d key=%h want all zero",
               busy0, ov0, done0, ri0, rk0);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ov0 || busy0 || done0) quiet_bad++;
    end
    vectors++;
    if (quiet_bad !== 0) begin
      miscompares++; $display("FAIL rst_quiet: got %0d active cycles want 0", quiet_bad);
    end
    collect(0, exp_rk[0], -1, 0, 1'b0);
    vectors++;
    if (obs_key.size() !== 11) begin
      miscompares++; $display("FAIL rst_restart_count: got %0d keys want 11", obs_key.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        vectors++;
        if (obs_key[i] !== exp_rk[10-i] || obs_idx[i] !== 10 - i) begin
          miscompares++;
          $display("FAIL rst_restart_key[%0d]: got idx %0d key %h want idx %0d key %h",
                   i, obs_idx[i], obs_key[i], 10 - i, exp_rk[10-i]);
        end
      end
    end
  endtask

  task automatic test_zero_key();
    collect(0, 128'h0, -1, 0, 1'b0);
    vectors++;
    if (obs_key.size() !== 11) begin
      miscompares++; $display("FAIL zero_count: got %0d keys want 11", obs_key.size());
    end else begin
      vectors++;
      if (obs_key[0] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e || obs_idx[0] !== 10) begin
        miscompares++;
        $display("FAIL zero_rk10: got idx %0d key %h want idx 10 key b4ef5bcb3e92e21123e951cf6f8f188e",
                 obs_idx[0], obs_key[0]);
      end
      vectors++;
      if (obs_key[10] !== 128'h0 || obs_idx[10] !== 0) begin
        miscompares++;
        $display("FAIL zero_rk0: got idx %0d key %h want idx 0 key 0", obs_idx[10], obs_key[10]);
      end
    end
  endtask

  initial begin
    exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
    key0 = '0; key1 = '0;
    test_reset();
    test_fips();
    test_backpressure();
    test_bypass();
    test_start_ignored();
    test_rst_mid();
    test_zero_key();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
